// File: rtl/avl_sram_if.sv
// Avalon-MM bus bundle between an initiator and the avl_sram responder.
//
// Signals (initiator -> responder):
//   address            byte address; bits [1:0] carry no meaning
//   byteenable         write byte lanes
//   lock               bus lock; the responder ignores it
//   read / write       command strobes; write also marks each write burst beat
//   writedata          write data
//   burstcount         beats per burst; 0 is treated as 1
// Signals (responder -> initiator):
//   readdata           read data, valid with readdatavalid
//   response           2'b00 OKAY, 2'b10 SLVERR; valid with readdatavalid or writeresponsevalid
//   waitrequest        command/beat not accepted this cycle
//   readdatavalid      one read beat returned
//   writeresponsevalid write burst completed
interface avl_sram_if;
  logic [31:0] address;
  logic [3:0]  byteenable;
  logic        lock;
  logic        read;
  logic [31:0] writedata;
  logic        write;
  logic [2:0]  burstcount;
  logic [31:0] readdata;
  logic [1:0]  response;
  logic        waitrequest;
  logic        readdatavalid;
  logic        writeresponsevalid;

  modport master (
    output address, byteenable, lock, read, writedata, write, burstcount,
    input  readdata, response, waitrequest, readdatavalid, writeresponsevalid
  );

  modport slave (
    input  address, byteenable, lock, read, writedata, write, burstcount,
    output readdata, response, waitrequest, readdatavalid, writeresponsevalid
  );
endinterface

// File: rtl/avl_sram.sv
// Avalon-MM responder in front of a single-port synchronous SRAM holding
// 2**ADDR_BITS 32-bit words, mapped at byte address MEM_BASE. Serves single and
// incrementing bursts (up to 7 beats), byte-lane writes, per-beat range errors
// (SLVERR) and one write response per write burst.
//
// Ports:
//   clock   single clock
//   reset   synchronous reset, active low; SRAM contents are retained
//   s_avl   avl_sram_if.slave bus (command, data, response and handshake)
//
// Parameters:
//   ADDR_BITS    word-address width
//   MEM_BASE     byte base address of the window (expected word aligned)
//   WAIT_CYCLES  wait states before each command acceptance
//
// Build option:
//   AVL_SRAM_WAIT_EN  when defined, every command arriving in IDLE sees
//                     waitrequest high for WAIT_CYCLES cycles before it is
//                     accepted. When undefined, commands are accepted at once
//                     and WAIT_CYCLES has no effect.
//
// Timing: a read accepted in cycle A returns beat k in cycle A+2+k. A write
// beat is written at the edge that accepts it; writeresponsevalid follows the
// last beat by one cycle and lasts one cycle.
module avl_sram #(
  parameter int          ADDR_BITS   = 12,
  parameter logic [31:0] MEM_BASE    = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 2
) (
  input logic       clock,
  input logic       reset,
  avl_sram_if.slave s_avl
);

  localparam int         DEPTH       = 1 << ADDR_BITS;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, READ, WRITE, WRESP} state_t;

  state_t      state, state_nxt;
  logic [2:0]  beat_cnt, beat_cnt_nxt;
  logic [2:0]  beat_last, beat_last_nxt;
  logic        werr, werr_nxt;
  logic        waitreq;
  logic        wait_done;
  logic        latch_cmd;
  logic        mem_we;
  logic        mem_re;

  logic [29:0] cmd_idx;
  logic [2:0]  cmd_last;
  logic [29:0] base_idx;
  logic [30:0] beat_idx;
  logic        beat_oor;

  logic [31:0] mem [DEPTH];
  logic [31:0] rd_data_p1;
  logic        rd_vld_p1;
  logic        rd_err_p1;

  // Burstcount 0 means a single beat; returns the index of the final beat.
  function automatic logic [2:0] last_beat(input logic [2:0] burstcount);
    return (burstcount == 3'd0) ? 3'd0 : burstcount - 3'd1;
  endfunction

  // A beat index lies outside the window when any bit above the SRAM address
  // is set. The index carries one spare bit so bursts running past the top of
  // the 32-bit space never wrap back into range.
  function automatic logic out_of_range(input logic [30:0] idx);
    return |idx[30:ADDR_BITS];
  endfunction

  // Word index relative to the window; the modular subtract sends addresses
  // below MEM_BASE to huge indices, which the range check then rejects.
  assign cmd_idx  = s_avl.address[31:2] - MEM_BASE[31:2];
  assign cmd_last = last_beat(s_avl.burstcount);

  // In IDLE the beat being accepted is beat 0 of the presented command;
  // otherwise it is beat beat_cnt of the latched burst.
  assign beat_idx = (state == IDLE) ? {1'b0, cmd_idx}
                                    : {1'b0, base_idx} + {28'd0, beat_cnt};
  assign beat_oor = out_of_range(beat_idx);

`ifdef AVL_SRAM_WAIT_EN
  localparam int WCNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  logic [WCNT_W-1:0] wait_cnt;
  logic              unused_inputs;

  assign wait_done = (wait_cnt == WCNT_W'(WAIT_CYCLES));

  // Counts cycles a command has been pending in IDLE; cleared on acceptance
  // or when nothing is pending, so each command gets its own full count.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (state == IDLE && !rd_vld_p1 && (s_avl.read || s_avl.write) && !wait_done) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  // Inputs with no effect on behaviour, gathered so their omission is visibly deliberate.
  assign unused_inputs = ^{s_avl.lock, s_avl.address[1:0]};
`else
  logic unused_inputs;

  assign wait_done = 1'b1;

  // Inputs with no effect on behaviour, gathered so their omission is visibly deliberate.
  assign unused_inputs = ^{s_avl.lock, s_avl.address[1:0], 32'(WAIT_CYCLES)};
`endif

  // waitrequest stays high in IDLE while the last read beat is still on the
  // bus, so a new command is only taken once the previous read has fully
  // drained.
  always_comb begin
    case (state)
      IDLE:    waitreq = rd_vld_p1 | ~wait_done;
      WRITE:   waitreq = 1'b0;
      default: waitreq = 1'b1;
    endcase
    if (!reset) waitreq = 1'b1;
  end

  always_comb begin
    state_nxt     = state;
    beat_cnt_nxt  = beat_cnt;
    beat_last_nxt = beat_last;
    werr_nxt      = werr;
    latch_cmd     = 1'b0;
    mem_we        = 1'b0;
    mem_re        = 1'b0;
    case (state)
      IDLE: begin
        // Write has priority when both strobes are presented together.
        if (!waitreq && s_avl.write) begin
          latch_cmd     = 1'b1;
          mem_we        = ~beat_oor;
          werr_nxt      = beat_oor;
          beat_last_nxt = cmd_last;
          beat_cnt_nxt  = (cmd_last == 3'd0) ? 3'd0 : 3'd1;
          state_nxt     = (cmd_last == 3'd0) ? WRESP : WRITE;
        end else if (!waitreq && s_avl.read) begin
          latch_cmd     = 1'b1;
          beat_last_nxt = cmd_last;
          beat_cnt_nxt  = 3'd0;
          state_nxt     = READ;
        end
      end
      READ: begin
        mem_re = 1'b1;
        if (beat_cnt == beat_last) begin
          beat_cnt_nxt = 3'd0;
          state_nxt    = IDLE;
        end else begin
          beat_cnt_nxt = beat_cnt + 3'd1;
        end
      end
      WRITE: begin
        if (s_avl.write) begin
          mem_we   = ~beat_oor;
          werr_nxt = werr | beat_oor;
          if (beat_cnt == beat_last) begin
            beat_cnt_nxt = 3'd0;
            state_nxt    = WRESP;
          end else begin
            beat_cnt_nxt = beat_cnt + 3'd1;
          end
        end
      end
      WRESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      beat_cnt  <= 3'd0;
      beat_last <= 3'd0;
      werr      <= 1'b0;
      rd_vld_p1 <= 1'b0;
      rd_err_p1 <= 1'b0;
    end else begin
      state     <= state_nxt;
      beat_cnt  <= beat_cnt_nxt;
      beat_last <= beat_last_nxt;
      werr      <= werr_nxt;
      rd_vld_p1 <= mem_re;
      rd_err_p1 <= mem_re & beat_oor;
    end
  end

  always_ff @(posedge clock) begin
    if (latch_cmd) base_idx <= cmd_idx;
  end

  // ---- stage p0 -> p1: SRAM access (registered read port, byte-lane write) ----
  always_ff @(posedge clock) begin
    rd_data_p1 <= mem[beat_idx[ADDR_BITS-1:0]];
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (s_avl.byteenable[i]) begin
          mem[beat_idx[ADDR_BITS-1:0]][8*i +: 8] <= s_avl.writedata[8*i +: 8];
        end
      end
    end
  end

  // Out-of-range read beats return zero data rather than whatever the
  // aliased SRAM word holds.
  assign s_avl.readdata           = (rd_vld_p1 && !rd_err_p1) ? rd_data_p1 : 32'd0;
  assign s_avl.readdatavalid      = rd_vld_p1;
  assign s_avl.writeresponsevalid = (state == WRESP);
  assign s_avl.waitrequest        = waitreq;
  assign s_avl.response           = rd_vld_p1 ? (rd_err_p1 ? RESP_SLVERR : RESP_OKAY)
                                  : ((state == WRESP) && werr) ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: tb/tb_avl_sram.sv
module tb_avl_sram;
  localparam int          ADDR_BITS   = 12;
  localparam logic [31:0] MEM_BASE    = 32'h0000_0000;
  localparam int          WAIT_CYCLES = 2;
  localparam int          DEPTH       = 1 << ADDR_BITS;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  avl_sram_if s_avl();

  avl_sram #(
    .ADDR_BITS  (ADDR_BITS),
    .MEM_BASE   (MEM_BASE),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clock(clock),
    .reset(reset),
    .s_avl(s_avl)
  );

  int checks   = 0;
  int failures = 0;

  // Reference memory: word-addressed image of the window.
  logic [31:0] model_mem [DEPTH];
  logic [31:0] last_rd;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Word index of beat k of a burst starting at byte address addr, computed
  // wide so it never wraps.
  function automatic longint unsigned widx(input logic [31:0] addr, input int k);
    logic [31:0] off;
    off = addr - MEM_BASE;
    return longint'(off >> 2) + longint'(k);
  endfunction

  task automatic do_read(input logic [31:0] addr, input logic [2:0] bc, input string tag);
    int n;
    int waits;
    longint unsigned idx;
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    n = (bc == 3'd0) ? 1 : int'(bc);
    waits = 0;
    s_avl.address = addr; s_avl.burstcount = bc; s_avl.read = 1'b1; s_avl.write = 1'b0;
    while (s_avl.waitrequest !== 1'b0 && waits < 50) begin cyc(); waits++; end
    checks++;
    if (s_avl.waitrequest !== 1'b0) begin
      failures++;
      $display("FAIL %s_accept waitrequest=%b required 0 within 50 cycles", tag, s_avl.waitrequest);
      s_avl.read = 1'b0;
      return;
    end
    cyc();
    s_avl.read = 1'b0;
    checks++;
    if (s_avl.readdatavalid !== 1'b0 || s_avl.waitrequest !== 1'b1) begin
      failures++;
      $display("FAIL %s_lat1 readdatavalid=%b waitrequest=%b required 0/1", tag, s_avl.readdatavalid, s_avl.waitrequest);
    end
    for (int k = 0; k < n; k++) begin
      cyc();
      idx = widx(addr, k);
      if (idx >= DEPTH) begin exp_d = 32'd0; exp_r = 2'b10; end
      else begin exp_d = model_mem[idx]; exp_r = 2'b00; end
      checks++;
      if (s_avl.readdatavalid !== 1'b1 || s_avl.readdata !== exp_d || s_avl.response !== exp_r) begin
        failures++;
        $display("FAIL %s_beat%0d valid=%b data=%h resp=%b required 1 %h %b", tag, k,
                 s_avl.readdatavalid, s_avl.readdata, s_avl.response, exp_d, exp_r);
      end
      checks++;
      if (s_avl.waitrequest !== 1'b1) begin
        failures++;
        $display("FAIL %s_busy%0d waitrequest=%b required 1", tag, k, s_avl.waitrequest);
      end
      last_rd = s_avl.readdata;
    end
    cyc();
    checks++;
    if (s_avl.readdatavalid !== 1'b0) begin
      failures++;
      $display("FAIL %s_extra readdatavalid=%b required 0", tag, s_avl.readdatavalid);
    end
`ifndef AVL_SRAM_WAIT_EN
    checks++;
    if (s_avl.waitrequest !== 1'b0) begin
      failures++;
      $display("FAIL %s_release waitrequest=%b required 0", tag, s_avl.waitrequest);
    end
`endif
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [2:0] bc,
                          input logic [31:0] wd [8], input logic [3:0] wbe [8],
                          input bit stalls, input bit with_read, input string tag);
    int n;
    int waits;
    int ns;
    bit err;
    longint unsigned idx;
    logic [1:0] exp_r;
    n = (bc == 3'd0) ? 1 : int'(bc);
    waits = 0;
    err = 1'b0;
    s_avl.address = addr; s_avl.burstcount = bc; s_avl.write = 1'b1; s_avl.read = with_read;
    s_avl.writedata = wd[0]; s_avl.byteenable = wbe[0];
    while (s_avl.waitrequest !== 1'b0 && waits < 50) begin cyc(); waits++; end
    checks++;
    if (s_avl.waitrequest !== 1'b0) begin
      failures++;
      $display("FAIL %s_accept waitrequest=%b required 0 within 50 cycles", tag, s_avl.waitrequest);
      s_avl.write = 1'b0; s_avl.read = 1'b0;
      return;
    end
    for (int k = 0; k < n; k++) begin
      // beat k is being accepted this cycle
      idx = widx(addr, k);
      if (idx >= DEPTH) err = 1'b1;
      else for (int b = 0; b < 4; b++) if (wbe[k][b]) model_mem[idx][8*b +: 8] = wd[k][8*b +: 8];
      cyc();
      if (k < n - 1) begin
        ns = stalls ? $urandom_range(0, 2) : 0;
        for (int s = 0; s < ns; s++) begin
          s_avl.write = 1'b0;
          checks++;
          if (s_avl.waitrequest !== 1'b0 || s_avl.writeresponsevalid !== 1'b0 || s_avl.readdatavalid !== 1'b0) begin
            failures++;
            $display("FAIL %s_stall waitrequest=%b wrv=%b rdv=%b required 0 0 0", tag,
                     s_avl.waitrequest, s_avl.writeresponsevalid, s_avl.readdatavalid);
          end
          cyc();
        end
        s_avl.write = 1'b1; s_avl.writedata = wd[k+1]; s_avl.byteenable = wbe[k+1];
        checks++;
        if (s_avl.waitrequest !== 1'b0 || s_avl.writeresponsevalid !== 1'b0) begin
          failures++;
          $display("FAIL %s_beat%0d waitrequest=%b wrv=%b required 0 0", tag, k + 1,
                   s_avl.waitrequest, s_avl.writeresponsevalid);
        end
      end
    end
    s_avl.write = 1'b0; s_avl.read = 1'b0;
    exp_r = err ? 2'b10 : 2'b00;
    checks++;
    if (s_avl.writeresponsevalid !== 1'b1 || s_avl.response !== exp_r || s_avl.readdatavalid !== 1'b0) begin
      failures++;
      $display("FAIL %s_resp wrv=%b resp=%b rdv=%b required 1 %b 0", tag,
               s_avl.writeresponsevalid, s_avl.response, s_avl.readdatavalid, exp_r);
    end
    cyc();
    checks++;
    if (s_avl.writeresponsevalid !== 1'b0 || s_avl.readdatavalid !== 1'b0) begin
      failures++;
      $display("FAIL %s_resp_once wrv=%b rdv=%b required 0 0", tag, s_avl.writeresponsevalid, s_avl.readdatavalid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cyc(); cyc();
    checks++;
    if (s_avl.waitrequest !== 1'b1 || s_avl.readdatavalid !== 1'b0 || s_avl.writeresponsevalid !== 1'b0 ||
        s_avl.readdata !== 32'd0 || s_avl.response !== 2'b00) begin
      failures++;
      $display("FAIL reset_state wr=%b rdv=%b wrv=%b rd=%h resp=%b required 1 0 0 0 00", s_avl.waitrequest,
               s_avl.readdatavalid, s_avl.writeresponsevalid, s_avl.readdata, s_avl.response);
    end
    reset = 1'b1;
    cyc();
`ifndef AVL_SRAM_WAIT_EN
    checks++;
    if (s_avl.waitrequest !== 1'b0) begin
      failures++;
      $display("FAIL reset_release waitrequest=%b required 0", s_avl.waitrequest);
    end
`endif
  endtask

  task automatic test_basic();
    logic [31:0] wd [8];
    logic [3:0]  wbe [8];
    wd = '{default: 32'd0}; wbe = '{default: 4'hF};
    wd[0] = 32'hDEAD_BEEF;
    do_write(32'h10, 3'd1, wd, wbe, 1'b0, 1'b0, "basic_wr");
    do_read(32'h10, 3'd1, "basic_rd");
    checks++;
    if (last_rd !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL basic_data readdata=%h required deadbeef", last_rd);
    end
  endtask

  task automatic test_byteen();
    logic [31:0] wd [8];
    logic [3:0]  wbe [8];
    wd = '{default: 32'd0}; wbe = '{default: 4'h0};
    wd[0] = 32'h1122_3344; wbe[0] = 4'b0101;
    do_write(32'h10, 3'd1, wd, wbe, 1'b0, 1'b0, "be_wr");
    do_read(32'h10, 3'd1, "be_rd");
    checks++;
    if (last_rd !== 32'hDE22_BE44) begin
      failures++;
      $display("FAIL be_data readdata=%h required de22be44", last_rd);
    end
    // No lanes enabled: nothing changes, response still OKAY; read also high (write wins).
    wd[0] = 32'hFFFF_FFFF; wbe[0] = 4'b0000;
    do_write(32'h10, 3'd1, wd, wbe, 1'b0, 1'b1, "be0_wr");
    do_read(32'h10, 3'd1, "be0_rd");
    checks++;
    if (last_rd !== 32'hDE22_BE44) begin
      failures++;
      $display("FAIL be0_data readdata=%h required de22be44", last_rd);
    end
  endtask

  task automatic test_burst_read();
    logic [31:0] wd [8];
    logic [3:0]  wbe [8];
    wd = '{default: 32'd0}; wbe = '{default: 4'hF};
    for (int i = 0; i < 4; i++) wd[i] = 32'(i + 1);
    do_write(32'h20, 3'd4, wd, wbe, 1'b1, 1'b1, "burst_wr");
    do_read(32'h20, 3'd4, "burst_rd");
    checks++;
    if (last_rd !== 32'd4) begin
      failures++;
      $display("FAIL burst_last readdata=%h required 00000004", last_rd);
    end
  endtask

  task automatic test_oor();
    logic [31:0] wd [8];
    logic [3:0]  wbe [8];
    wd = '{default: 32'd0}; wbe = '{default: 4'hF};
    do_read(MEM_BASE + 32'(4 * DEPTH), 3'd1, "oor_rd");
    wd[0] = 32'hCAFE_F00D; wd[1] = 32'h1234_5678;
    do_write(MEM_BASE + 32'(4 * (DEPTH - 1)), 3'd2, wd, wbe, 1'b0, 1'b0, "oor_wr");
    do_read(MEM_BASE + 32'(4 * (DEPTH - 1)), 3'd1, "oor_last");
    checks++;
    if (last_rd !== 32'hCAFE_F00D) begin
      failures++;
      $display("FAIL oor_last_data readdata=%h required cafef00d", last_rd);
    end
    do_read(MEM_BASE - 32'd4, 3'd1, "below_base");
  endtask

`ifdef AVL_SRAM_WAIT_EN
  task automatic test_wait();
    int waits;
    waits = 0;
    s_avl.address = 32'h10; s_avl.burstcount = 3'd1; s_avl.read = 1'b1; s_avl.write = 1'b0;
    while (s_avl.waitrequest === 1'b1 && waits < 20) begin cyc(); waits++; end
    checks++;
    if (waits != WAIT_CYCLES || s_avl.waitrequest !== 1'b0) begin
      failures++;
      $display("FAIL wait_states waited=%0d required %0d", waits, WAIT_CYCLES);
    end
    cyc();
    s_avl.read = 1'b0;
    checks++;
    if (s_avl.readdatavalid !== 1'b0) begin
      failures++;
      $display("FAIL wait_lat1 readdatavalid=%b required 0", s_avl.readdatavalid);
    end
    cyc();
    checks++;
    if (s_avl.readdatavalid !== 1'b1 || s_avl.readdata !== model_mem[4]) begin
      failures++;
      $display("FAIL wait_data valid=%b data=%h required 1 %h", s_avl.readdatavalid, s_avl.readdata, model_mem[4]);
    end
    cyc();
  endtask
`endif

  task automatic test_random();
    logic [31:0] wd [8];
    logic [3:0]  wbe [8];
    logic [31:0] addr;
    logic [2:0]  bc;
    wd = '{default: 32'd0}; wbe = '{default: 4'hF};
    for (int i = 0; i < 24; i++) begin
      wd[0] = $urandom;
      do_write(MEM_BASE + 32'h400 + 32'(4 * i), 3'd1, wd, wbe, 1'b0, 1'b0, "fill");
    end
    for (int i = 0; i < 4; i++) begin
      wd[0] = $urandom;
      do_write(MEM_BASE + 32'(4 * (DEPTH - 4 + i)), 3'd1, wd, wbe, 1'b0, 1'b0, "fill_top");
    end
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) addr = MEM_BASE + 32'(4 * (DEPTH - 4 + int'($urandom_range(0, 3))));
      else addr = MEM_BASE + 32'h400 + 32'(4 * int'($urandom_range(0, 15)));
      addr = addr | 32'($urandom_range(0, 3));
      bc = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < 8; k++) begin wd[k] = $urandom; wbe[k] = 4'($urandom_range(0, 15)); end
        do_write(addr, bc, wd, wbe, 1'b1, 1'($urandom_range(0, 1)), "rnd_wr");
      end else begin
        do_read(addr, bc, "rnd_rd");
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int waits;
    waits = 0;
    s_avl.address = 32'h20; s_avl.burstcount = 3'd4; s_avl.read = 1'b1; s_avl.write = 1'b0;
    while (s_avl.waitrequest !== 1'b0 && waits < 50) begin cyc(); waits++; end
    cyc();
    s_avl.read = 1'b0;
    cyc();
    cyc();
    checks++;
    if (s_avl.readdatavalid !== 1'b1 || s_avl.readdata !== 32'd2) begin
      failures++;
      $display("FAIL rstmid_beat1 valid=%b data=%h required 1 00000002", s_avl.readdatavalid, s_avl.readdata);
    end
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      checks++;
      if (s_avl.readdatavalid !== 1'b0 || s_avl.waitrequest !== 1'b1) begin
        failures++;
        $display("FAIL rstmid_in_reset rdv=%b waitrequest=%b required 0 1", s_avl.readdatavalid, s_avl.waitrequest);
      end
    end
    reset = 1'b1;
    cyc();
`ifndef AVL_SRAM_WAIT_EN
    checks++;
    if (s_avl.waitrequest !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_release waitrequest=%b required 0", s_avl.waitrequest);
    end
`endif
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (s_avl.readdatavalid !== 1'b0 || s_avl.writeresponsevalid !== 1'b0) begin
        failures++;
        $display("FAIL rstmid_after rdv=%b wrv=%b required 0 0", s_avl.readdatavalid, s_avl.writeresponsevalid);
      end
      cyc();
    end
    do_read(32'h20, 3'd4, "rstmid_retained");
  endtask

  initial begin
    s_avl.address = 32'd0; s_avl.byteenable = 4'h0; s_avl.lock = 1'b0; s_avl.read = 1'b0;
    s_avl.writedata = 32'd0; s_avl.write = 1'b0; s_avl.burstcount = 3'd1;
    last_rd = 32'd0;
    test_reset();
    test_basic();
    test_byteen();
    test_burst_read();
    test_oor();
`ifdef AVL_SRAM_WAIT_EN
    test_wait();
`endif
    test_random();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
